pattern_blink_seq: RTL and testbench

- Parametrised successor to the board's slow LED blinker and chip-select rotator.
- Free-running prescaler produces a slow step tick. On each tick the block:
  - rotates an active-low one-hot chip-select bus across CS_W lines;
  - advances an LED pattern in one of four run-time modes: blink, shift, bounce, count.
- Sits directly behind the board pins; drives the LED bank and display/peripheral selects.

---
 rtl/pattern_blink_seq.sv | 122 ++++++++++++
 tb/tb_pattern_blink_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_blink_seq.sv
// Slow step generator that rotates an active-low chip select and animates an LED bank.
// Define LED_PWM_EN to add a 4-bit duty input that dims the LED outputs.
module pattern_blink_seq #(
    parameter int              CNT_W   = 24,
    parameter logic [CNT_W-1:0] DIV_MAX = CNT_W'(24'hFFFFFF),
    parameter int              LED_W   = 8,
    parameter int              CS_W    = 3,
    localparam int             IDX_W   = $clog2(CS_W)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
`ifdef LED_PWM_EN
    input  logic [3:0]        duty,
`endif
    output logic [LED_W-1:0]  led,
    output logic [CS_W-1:0]   cs,
    output logic              tick,
    output logic [IDX_W-1:0]  cs_idx
);

    typedef enum logic [1:0] {
        M_BLINK  = 2'd0,
        M_SHIFT  = 2'd1,
        M_BOUNCE = 2'd2,
        M_COUNT  = 2'd3
    } mode_t;

    logic [CNT_W-1:0] r_presc;
    logic             r_tick;
    logic [LED_W-1:0] r_led;
    logic [CS_W-1:0]  r_cs;
    logic [IDX_W-1:0] r_idx;
    mode_t            r_mode_q;
    logic             r_dir_up;

    logic             w_step;
    logic [IDX_W-1:0] w_idx_next;
    logic [LED_W-1:0] w_up;
    logic [LED_W-1:0] w_dn;
    logic [LED_W-1:0] w_pat_next;
    logic             w_dir_next;

    assign w_step     = en && (r_presc == DIV_MAX);
    assign w_idx_next = (r_idx == IDX_W'(CS_W - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_up       = r_led << 1;
    assign w_dn       = r_led >> 1;

    // A mode change loads the new mode's seed instead of stepping the pattern.
    always_comb begin
        w_pat_next = r_led;
        w_dir_next = r_dir_up;
        if (mode != 2'(r_mode_q)) begin
            w_pat_next = (mode_t'(mode) == M_SHIFT || mode_t'(mode) == M_BOUNCE)
                         ? LED_W'(1) : '0;
            w_dir_next = 1'b1;
        end else begin
            case (r_mode_q)
                M_BLINK: w_pat_next = ~r_led;
                M_SHIFT: w_pat_next = w_up | (r_led >> (LED_W - 1));
                M_BOUNCE: begin
                    if (LED_W == 1) begin
                        w_pat_next = LED_W'(1);
                    end else if (r_dir_up) begin
                        w_pat_next = w_up;
                        if (w_up[LED_W-1])
                            w_dir_next = 1'b0;
                    end else begin
                        w_pat_next = w_dn;
                        if (w_dn[0])
                            w_dir_next = 1'b1;
                    end
                end
                default: w_pat_next = r_led + LED_W'(1);
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_led    <= '0;
            r_cs     <= ~CS_W'(1);
            r_idx    <= '0;
            r_mode_q <= M_BLINK;
            r_dir_up <= 1'b1;
        end else begin
            r_tick <= w_step;
            if (en)
                r_presc <= w_step ? '0 : r_presc + CNT_W'(1);
            if (w_step) begin
                r_idx    <= w_idx_next;
                r_cs     <= ~(CS_W'(1) << w_idx_next);
                r_mode_q <= mode_t'(mode);
                r_led    <= w_pat_next;
                r_dir_up <= w_dir_next;
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge ck) begin
        if (rst)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 4'd1;
    end

    assign led = r_led & {LED_W{r_pwm < duty}};
`else
    assign led = r_led;
`endif

    assign cs     = r_cs;
    assign tick   = r_tick;
    assign cs_idx = r_idx;

endmodule

// File: tb/tb_pattern_blink_seq.sv
// Self-checking bench for pattern_blink_seq: vector table plus tick scoreboard and corner sequences.
// Build with LED_PWM_EN defined to also exercise the dimming path.
module tb_pattern_blink_seq;

    localparam int               CNT_W   = 24;
    localparam logic [CNT_W-1:0] DIV_MAX = 24'd3;
    localparam int               LED_W   = 8;
    localparam int               CS_W    = 3;

    logic       ck = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
`ifdef LED_PWM_EN
    logic [3:0] duty;
`endif
    logic [7:0] led;
    logic [2:0] cs;
    logic       tick;
    logic [1:0] cs_idx;

    pattern_blink_seq #(
        .CNT_W(CNT_W), .DIV_MAX(DIV_MAX), .LED_W(LED_W), .CS_W(CS_W)
    ) dut (
        .ck(ck),
        .rst(rst),
        .en(en),
        .mode(mode),
`ifdef LED_PWM_EN
        .duty(duty),
`endif
        .led(led),
        .cs(cs),
        .tick(tick),
        .cs_idx(cs_idx)
    );

    always #5 ck = ~ck;

    typedef struct { logic [1:0] mode; logic [7:0] led; } vec_t;
    typedef struct { logic [7:0] led; logic [2:0] cs; logic [1:0] idx; } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [2:0] cs_tab [3];
    int         exp_idx;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // With dimming compiled in, a dark cycle is also a legal view of the pattern.
    task automatic check_led(input string name, input logic [7:0] act, input logic [7:0] req);
`ifdef LED_PWM_EN
        check(name, (act === req || act === 8'h00) ? act : 32'hDEAD, act);
        if (act !== req && act !== 8'h00)
            $display("  detail %s: led %02h vs %02h", name, act, req);
`else
        check(name, act, req);
`endif
    endtask

    task automatic push_exp(input logic [7:0] l);
        exp_t e;
        exp_idx = (exp_idx + 1) % 3;
        e.led = l;
        e.cs  = cs_tab[exp_idx];
        e.idx = 2'(exp_idx);
        sb.push_back(e);
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [7:0] l);
        vec_t v;
        v.mode = m;
        v.led  = l;
        vecs.push_back(v);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(posedge ck);
            #1;
            n++;
        end while (!tick && n < 20);
    endtask

    always @(negedge ck) begin
        exp_t e;
        if (!rst && tick) begin
            if (sb.size() == 0) begin
                check("unexpected_tick", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("tick led=%02h cs=%03b idx=%0d (exp %02h %03b %0d)",
                         led, cs, cs_idx, e.led, e.cs, e.idx);
                check_led("tick_led", led, e.led);
                check("tick_cs", 32'(cs), 32'(e.cs));
                check("tick_idx", 32'(cs_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        int         n;
        logic [7:0] hold_led;
        logic [2:0] hold_cs;
        int         on_cnt;
        int         odd_cnt;

        cs_tab[0] = 3'b110;
        cs_tab[1] = 3'b101;
        cs_tab[2] = 3'b011;

        add_vec(2'd0, 8'hFF); add_vec(2'd0, 8'h00); add_vec(2'd0, 8'hFF);
        add_vec(2'd1, 8'h01); add_vec(2'd1, 8'h02); add_vec(2'd1, 8'h04);
        add_vec(2'd1, 8'h08); add_vec(2'd1, 8'h10); add_vec(2'd1, 8'h20);
        add_vec(2'd1, 8'h40); add_vec(2'd1, 8'h80); add_vec(2'd1, 8'h01);
        add_vec(2'd2, 8'h01); add_vec(2'd2, 8'h02); add_vec(2'd2, 8'h04);
        add_vec(2'd2, 8'h08); add_vec(2'd2, 8'h10); add_vec(2'd2, 8'h20);
        add_vec(2'd2, 8'h40); add_vec(2'd2, 8'h80); add_vec(2'd2, 8'h40);
        add_vec(2'd2, 8'h20); add_vec(2'd2, 8'h10); add_vec(2'd2, 8'h08);
        add_vec(2'd2, 8'h04); add_vec(2'd2, 8'h02); add_vec(2'd2, 8'h01);
        add_vec(2'd2, 8'h02);

        rst = 1'b1; en = 1'b0; mode = 2'd0; exp_idx = 0;
`ifdef LED_PWM_EN
        duty = 4'd15;
`endif
        repeat (2) @(posedge ck);
        #1;
        check("rst_led", 32'(led), 32'h00);
        check("rst_cs", 32'(cs), 32'b110);
        check("rst_idx", 32'(cs_idx), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);

        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            mode = vecs[i].mode;
            push_exp(vecs[i].led);
            wait_tick(n);
            check("tick_period", n, 4);
        end

        // COUNT: seed, full wrap, then a few more before switching back to BLINK
        mode = 2'd3;
        push_exp(8'h00);
        wait_tick(n);
        check("count_seed_period", n, 4);
        for (int k = 1; k <= 261; k++) begin
            push_exp(8'(k));
            wait_tick(n);
            if (k % 64 == 0 || k == 261)
                check("count_period", n, 4);
        end
        mode = 2'd0;
        push_exp(8'h00);
        wait_tick(n);
        push_exp(8'hFF);
        wait_tick(n);
        check("blink_after_count_period", n, 4);

        // en dropped exactly when the prescaler sits at its terminal count
        repeat (3) @(posedge ck);
        #1;
        en = 1'b0;
        @(posedge ck);
        #1;
        check("en_fall_no_tick", 32'(tick), 32'd0);
        en = 1'b1;
        push_exp(8'h00);
        wait_tick(n);
        check("en_fall_resume", n, 1);

        // pause for ten clocks with the prescaler at 2
        repeat (2) @(posedge ck);
        #1;
        en = 1'b0;
        hold_led = led;
        hold_cs  = cs;
        for (int c = 0; c < 10; c++) begin
            @(posedge ck);
            #1;
            check("pause_tick", 32'(tick), 32'd0);
            check_led("pause_led", led, hold_led);
            check("pause_cs", 32'(cs), 32'(hold_cs));
        end
        en = 1'b1;
        push_exp(8'hFF);
        wait_tick(n);
        check("pause_resume", n, 2);

        // reset in the middle of BOUNCE
        mode = 2'd2;
        push_exp(8'h01); wait_tick(n);
        push_exp(8'h02); wait_tick(n);
        push_exp(8'h04); wait_tick(n);
        @(posedge ck);
        #1;
        rst = 1'b1;
        @(posedge ck);
        #1;
        check("midrst_led", 32'(led), 32'h00);
        check("midrst_cs", 32'(cs), 32'b110);
        check("midrst_idx", 32'(cs_idx), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        exp_idx = 0;
        push_exp(8'h01);
        wait_tick(n);
        check("midrst_restart", n, 4);

`ifdef LED_PWM_EN
        mode = 2'd0;
        push_exp(8'h00); wait_tick(n);
        push_exp(8'hFF); wait_tick(n);
        en = 1'b0;
        duty = 4'd4;
        on_cnt = 0; odd_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge ck);
            #1;
            if (led === 8'hFF) on_cnt++;
            else if (led !== 8'h00) odd_cnt++;
        end
        check("pwm_duty4_on", on_cnt, 4);
        check("pwm_duty4_odd", odd_cnt, 0);
        duty = 4'd0;
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge ck);
            #1;
            if (led !== 8'h00) on_cnt++;
        end
        check("pwm_duty0_dark", on_cnt, 0);
        en = 1'b1;
`else
        on_cnt = 0;
        odd_cnt = 0;
`endif

        @(negedge ck);
        @(negedge ck);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
